imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 Parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single output register with combinational ready.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instr  input  32  instruction word; only bits [31:7] used.
REQ-006 imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 ZIMM, 111 reserved.
REQ-007 in_valid  input  1  instr/imm_src valid.
REQ-008 in_ready  output  1  block can accept this cycle.
REQ-009 flush  input  1  synchronous kill of all buffered entries.
REQ-010 out_valid  output  1  immext/illegal valid.
REQ-011 out_ready  input  1  consumer accepts this cycle.
REQ-012 immext  output  XLEN  extended immediate.
REQ-013 illegal  output  1  entry was decoded with reserved imm_src.
REQ-014 occupancy  output  2  entries held (0..2).

Function
REQ-015 I: sign-extend instr[31:20] to XLEN.
REQ-016 S: sign-extend {instr[31:25], instr[11:7]}.
REQ-017 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-018 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-019 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-020 SHAMT: zero-extend instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
REQ-021 ZIMM: zero-extend instr[19:15].
REQ-022 Reserved (111): immext = 0, illegal = 1; all other formats illegal = 0.
REQ-023 Extension is computed at input and registered; latency from accepted input to out_valid is exactly 1 cycle.
REQ-024 Input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-025 SKID=1: in_ready is a register output, = 1 when occupancy < 2; no combinational path from out_ready to in_ready.
REQ-026 SKID=1: when output register is full, not consumed, and an input is accepted, the new entry goes to the skid register; when output is consumed, skid entry (if any) moves to the output the same edge.
REQ-027 Simultaneous accept and consume at occupancy 1: occupancy stays 1, output register takes new entry.
REQ-028 Entries leave strictly in acceptance order; no entry duplicated or dropped except by flush/reset.
REQ-029 out_valid held with immext/illegal stable until consumed.
REQ-030 SKID=0: in_ready = !out_valid || out_ready; occupancy never exceeds 1.
REQ-031 flush: next edge clears all valid bits, occupancy = 0; an input presented in the flush cycle is dropped; in_ready = 1 the cycle after.
REQ-032 flush takes priority over simultaneous accept and consume.

Reset
REQ-033 On reset assertion, asynchronously: out_valid = 0, occupancy = 0, in_ready = 1, immext = 0, illegal = 0.
REQ-034 Reset mid-operation discards all entries; no output handshake completes while reset is high.

Structure
REQ-035 imm_src encodings (enum imm_src_t) and XLEN default constant live in the shared core package.
REQ-036 Combinational format decode is sub-module imm_extend_comb (instr, imm_src -> immext, illegal), instantiated once at the input.

Verification
REQ-037 XLEN=32, I, instr 0xFFF00093, out_ready=1 -> next cycle out_valid=1, immext 0xFFFFFFFF, illegal 0.
REQ-038 S, instr 0xFE112E23 -> immext 0xFFFFFFFC; J, instr 0x0010006F -> immext 0x00000800; U, instr 0x123450B7 -> 0x12345000.
REQ-039 SKID=1, out_ready=0, three back-to-back inputs -> occupancy 2, in_ready 0 after second, third not accepted; release out_ready -> outputs in order, no loss.
REQ-040 imm_src=111 with any instr -> immext 0, illegal 1; flush at occupancy 2 -> occupancy 0, out_valid 0 next cycle.
REQ-041 XLEN=64, I, instr 0xFFF00093 -> immext 0xFFFFFFFFFFFFFFFF; SHAMT, instr 0x03F01013 -> immext 0x3F.
REQ-042 Reset asserted mid-stream at occupancy 2 -> out_valid 0 immediately (asynchronously), in_ready 1, no stale entry after release.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// Shared core definitions for the immediate-extension pipeline: the
// imm_src format encodings and the default output width.
package imm_extend_pipe_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_S     = 3'b001,
      IMM_B     = 3'b010,
      IMM_J     = 3'b011,
      IMM_U     = 3'b100,
      IMM_SHAMT = 3'b101,
      IMM_ZIMM  = 3'b110,
      IMM_RSVD  = 3'b111
   } imm_src_t;

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational immediate decode: gathers the scattered instruction fields
// for the selected format and sign- or zero-extends them to XLEN.
module imm_extend_comb
   import imm_extend_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] immext,
   output logic            illegal
);

   // Natural-width fields; the signed ones sign-extend when cast up to XLEN.
   logic signed [11:0] imm_i;
   logic signed [11:0] imm_s;
   logic signed [12:0] imm_b;
   logic signed [20:0] imm_j;
   logic signed [31:0] imm_u;
   logic        [5:0]  shamt;
   logic        [4:0]  zimm;
   logic               unused_opcode;

   assign imm_i = instr[31:20];
   assign imm_s = {instr[31:25], instr[11:7]};
   assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   // RV64 shift amounts carry one extra bit.
   assign shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
   assign zimm  = instr[19:15];

   // Opcode bits carry no immediate information.
   assign unused_opcode = ^instr[6:0];

   // Format select; reserved encoding yields zero and flags the entry.
   always_comb begin
      immext  = '0;
      illegal = 1'b0;
      case (imm_src_t'(imm_src))
         IMM_I:     immext = XLEN'(imm_i);
         IMM_S:     immext = XLEN'(imm_s);
         IMM_B:     immext = XLEN'(imm_b);
         IMM_J:     immext = XLEN'(imm_j);
         IMM_U:     immext = XLEN'(imm_u);
         IMM_SHAMT: immext = XLEN'(shamt);
         IMM_ZIMM:  immext = XLEN'(zimm);
         default: begin
            immext  = '0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage with valid/ready handshake. The decode is done
// at the input and registered; SKID=1 adds a second entry so in_ready can
// be a flop, SKID=0 uses one register with a combinational ready.
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] immext,
   output logic            illegal,
   output logic [1:0]      occupancy
);

   logic [XLEN-1:0] imm_p0;
   logic            ill_p0;

   logic            vld_p1;
   logic [XLEN-1:0] imm_p1;
   logic            ill_p1;
   logic            skid_vld_p1;
   logic [XLEN-1:0] skid_imm_p1;
   logic            skid_ill_p1;

   logic            vld_n;
   logic [XLEN-1:0] imm_n;
   logic            ill_n;
   logic            skid_vld_n;
   logic [XLEN-1:0] skid_imm_n;
   logic            skid_ill_n;

   logic            accept;
   logic            consume;

   // ---- stage p0: decode at the input ----
   imm_extend_comb #(.XLEN(XLEN)) u_comb (
      .instr   (instr),
      .imm_src (imm_src),
      .immext  (imm_p0),
      .illegal (ill_p0)
   );

   assign accept  = in_valid && in_ready;
   assign consume = vld_p1 && out_ready;

   // Next-state for output and skid entries; flush overrides any handshake.
   always_comb begin
      vld_n      = vld_p1;
      imm_n      = imm_p1;
      ill_n      = ill_p1;
      skid_vld_n = skid_vld_p1;
      skid_imm_n = skid_imm_p1;
      skid_ill_n = skid_ill_p1;
      if (flush) begin
         vld_n      = 1'b0;
         skid_vld_n = 1'b0;
      end else if (!vld_p1) begin
         if (accept) begin
            vld_n = 1'b1;
            imm_n = imm_p0;
            ill_n = ill_p0;
         end
      end else if (!skid_vld_p1) begin
         if (consume && accept) begin
            imm_n = imm_p0;
            ill_n = ill_p0;
         end else if (consume) begin
            vld_n = 1'b0;
         end else if (accept && (SKID != 0)) begin
            skid_vld_n = 1'b1;
            skid_imm_n = imm_p0;
            skid_ill_n = ill_p0;
         end
      end else if (consume) begin
         // Skid is full, so in_ready was low: only a move-up is possible.
         imm_n      = skid_imm_p1;
         ill_n      = skid_ill_p1;
         skid_vld_n = 1'b0;
      end
   end

   // ---- stage p1: output and skid registers ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1      <= 1'b0;
         imm_p1      <= '0;
         ill_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         skid_imm_p1 <= '0;
         skid_ill_p1 <= 1'b0;
      end else begin
         vld_p1      <= vld_n;
         imm_p1      <= imm_n;
         ill_p1      <= ill_n;
         skid_vld_p1 <= skid_vld_n;
         skid_imm_p1 <= skid_imm_n;
         skid_ill_p1 <= skid_ill_n;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic rdy_q;
         // Registered ready: low only when both entries will be held.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) rdy_q <= 1'b1;
            else       rdy_q <= !(vld_n && skid_vld_n);
         end
         assign in_ready = rdy_q;
      end else begin : g_noskid
         assign in_ready = !vld_p1 || out_ready;
      end
   endgenerate

   assign out_valid = vld_p1;
   assign immext    = imm_p1;
   assign illegal   = ill_p1;
   assign occupancy = {1'b0, vld_p1} + {1'b0, skid_vld_p1};

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32/SKID=1 instance (u_dut) and
// XLEN=64/SKID=0 instance (u_dut64), checked against an arithmetic model.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, instr_b;
   logic [2:0]  imm_src, imm_src_b;
   logic        in_valid, in_valid_b, in_ready, in_ready_b;
   logic        flush, flush_b, out_valid, out_valid_b, out_ready, out_ready_b;
   logic [31:0] immext;
   logic [63:0] immext_b;
   logic        illegal, illegal_b;
   logic [1:0]  occupancy, occupancy_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] imm;
      bit          ill;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   imm_extend_pipe #(.XLEN(32), .SKID(1)) u_dut (
      .clk(clk), .reset(reset), .instr(instr), .imm_src(imm_src),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .immext(immext),
      .illegal(illegal), .occupancy(occupancy)
   );

   imm_extend_pipe #(.XLEN(64), .SKID(0)) u_dut64 (
      .clk(clk), .reset(reset), .instr(instr_b), .imm_src(imm_src_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .immext(immext_b),
      .illegal(illegal_b), .occupancy(occupancy_b)
   );

   // Immediate value from the format rules, using integer arithmetic.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int src,
                                           input int xlen, output bit ill);
      longint u, v;
      u   = longint'(ins);
      v   = 0;
      ill = 1'b0;
      case (src)
         0: begin v = (u >> 20) & 'hFFF; if (v >= 2048) v -= 4096; end
         1: begin
            v = (((u >> 25) & 'h7F) << 5) + ((u >> 7) & 'h1F);
            if (v >= 2048) v -= 4096;
         end
         2: begin
            v = (((u >> 31) & 1) << 12) + (((u >> 7) & 1) << 11)
              + (((u >> 25) & 'h3F) << 5) + (((u >> 8) & 'hF) << 1);
            if (v >= 4096) v -= 8192;
         end
         3: begin
            v = (((u >> 31) & 1) << 20) + (((u >> 12) & 'hFF) << 12)
              + (((u >> 20) & 1) << 11) + (((u >> 21) & 'h3FF) << 1);
            if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
         end
         4: begin
            v = u & 'hFFFFF000;
            if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32);
         end
         5: v = (u >> 20) & ((xlen == 64) ? 'h3F : 'h1F);
         6: v = (u >> 15) & 'h1F;
         default: begin v = 0; ill = 1'b1; end
      endcase
      if (xlen == 32) v = v & 'hFFFFFFFF;
      return v;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      total += 5;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      if (immext !== 32'h0)   begin bad++; $display("FAIL rst_immext: got %h want 0", immext); end
      if (illegal !== 1'b0)   begin bad++; $display("FAIL rst_illegal: got %b want 0", illegal); end
      reset = 1'b0;
      next_cycle();
   endtask

   task automatic test_vectors32();
      logic [31:0] vi [5];
      logic [2:0]  vs [5];
      logic [31:0] ve [5];
      logic        vl [5];
      vi = '{32'hFFF00093, 32'hFE112E23, 32'h0010006F, 32'h123450B7, $urandom};
      vs = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd7};
      ve = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h12345000, 32'h0};
      vl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; instr = vi[i]; imm_src = vs[i]; out_ready = 1'b1;
         next_cycle();
         in_valid = 1'b0;
         total += 3;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid: got %b want 1", i, out_valid); end
         if (immext !== ve[i])   begin bad++; $display("FAIL vec%0d_immext: got %h want %h", i, immext, ve[i]); end
         if (illegal !== vl[i])  begin bad++; $display("FAIL vec%0d_illegal: got %b want %b", i, illegal, vl[i]); end
         next_cycle();
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_drain: got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; imm_src = 3'd0;
      in_valid = 1'b1; instr = 32'h00100093;
      next_cycle();
      total += 2;
      if (occupancy !== 2'd1) begin bad++; $display("FAIL b2b_occ1: got %0d want 1", occupancy); end
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL b2b_rdy1: got %b want 1", in_ready); end
      instr = 32'h00200093;
      next_cycle();
      total += 2;
      if (occupancy !== 2'd2) begin bad++; $display("FAIL b2b_occ2: got %0d want 2", occupancy); end
      if (in_ready !== 1'b0)  begin bad++; $display("FAIL b2b_rdy2: got %b want 0", in_ready); end
      instr = 32'h00300093;
      next_cycle();
      in_valid = 1'b0;
      total += 2;
      if (occupancy !== 2'd2) begin bad++; $display("FAIL b2b_occ3: got %0d want 2", occupancy); end
      if (immext !== 32'd1)   begin bad++; $display("FAIL b2b_first: got %h want 1", immext); end
      out_ready = 1'b1;
      next_cycle();
      total += 3;
      if (occupancy !== 2'd1) begin bad++; $display("FAIL b2b_occ4: got %0d want 1", occupancy); end
      if (immext !== 32'd2)   begin bad++; $display("FAIL b2b_second: got %h want 2", immext); end
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL b2b_rdy4: got %b want 1", in_ready); end
      next_cycle();
      total += 2;
      if (occupancy !== 2'd0) begin bad++; $display("FAIL b2b_occ5: got %0d want 0", occupancy); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; imm_src = 3'd0; in_valid = 1'b1;
      instr = 32'h00400093; next_cycle();
      instr = 32'h00500093; next_cycle();
      total++;
      if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_fill: got %0d want 2", occupancy); end
      // Input and consume presented together with flush; flush must win.
      instr = 32'h00600093; flush = 1'b1; out_ready = 1'b1;
      next_cycle();
      flush = 1'b0; in_valid = 1'b0;
      total += 3;
      if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL flush_rdy: got %b want 1", in_ready); end
      next_cycle();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; imm_src = 3'd0; in_valid = 1'b1;
      instr = 32'h00700093; next_cycle();
      instr = 32'h00800093; next_cycle();
      in_valid = 1'b0;
      total++;
      if (occupancy !== 2'd2) begin bad++; $display("FAIL arst_fill: got %0d want 2", occupancy); end
      #2 reset = 1'b1;
      #1;
      total += 4;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL arst_rdy: got %b want 1", in_ready); end
      if (occupancy !== 2'd0) begin bad++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
      if (immext !== 32'h0)   begin bad++; $display("FAIL arst_immext: got %h want 0", immext); end
      next_cycle();
      reset = 1'b0;
      out_ready = 1'b1;
      next_cycle();
      next_cycle();
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_stale: got %b want 0", out_valid); end
      if (occupancy !== 2'd0) begin bad++; $display("FAIL arst_stale_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_random();
      ent_t        e;
      logic [63:0] r;
      bit          ill, acc, con;
      int          rdy_bias;
      q.delete();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 600; c++) begin
         total += 3;
         if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, q.size() > 0); end
         if (occupancy !== 2'(q.size()))   begin bad++; $display("FAIL rnd_occ@%0d: got %0d want %0d", c, occupancy, q.size()); end
         if (in_ready !== (q.size() < 2))  begin bad++; $display("FAIL rnd_rdy@%0d: got %b want %b", c, in_ready, q.size() < 2); end
         if (q.size() > 0) begin
            total += 2;
            if (immext !== q[0].imm[31:0]) begin bad++; $display("FAIL rnd_immext@%0d: got %h want %h", c, immext, q[0].imm[31:0]); end
            if (illegal !== q[0].ill)      begin bad++; $display("FAIL rnd_illegal@%0d: got %b want %b", c, illegal, q[0].ill); end
         end
         rdy_bias  = (c / 50) % 3;
         in_valid  = ($urandom_range(0, 3) != 0);
         instr     = $urandom;
         imm_src   = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 2) < rdy_bias + 0) || (rdy_bias == 2);
         flush     = ($urandom_range(0, 31) == 0);
         acc = in_valid && (q.size() < 2);
         con = (q.size() > 0) && out_ready;
         r = ref_imm(instr, int'(imm_src), 32, ill);
         e.imm = r; e.ill = ill;
         if (flush) q.delete();
         else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
         end
         next_cycle();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      next_cycle(); next_cycle();
   endtask

   task automatic test_xlen64();
      logic [31:0] vi [3];
      logic [2:0]  vs [3];
      logic [63:0] ve [3];
      logic [63:0] r;
      bit          ill;
      vi = '{32'hFFF00093, 32'h03F01013, 32'h823450B7};
      vs = '{3'd0, 3'd5, 3'd4};
      ve = '{64'hFFFFFFFFFFFFFFFF, 64'h3F, 64'hFFFFFFFF82345000};
      for (int i = 0; i < 3; i++) begin
         in_valid_b = 1'b1; instr_b = vi[i]; imm_src_b = vs[i]; out_ready_b = 1'b1;
         next_cycle();
         in_valid_b = 1'b0;
         total += 2;
         if (out_valid_b !== 1'b1) begin bad++; $display("FAIL x64_vec%0d_valid: got %b want 1", i, out_valid_b); end
         if (immext_b !== ve[i])   begin bad++; $display("FAIL x64_vec%0d_immext: got %h want %h", i, immext_b, ve[i]); end
         next_cycle();
      end
      for (int i = 0; i < 40; i++) begin
         in_valid_b = 1'b1; instr_b = $urandom; imm_src_b = 3'($urandom_range(0, 7));
         r = ref_imm(instr_b, int'(imm_src_b), 64, ill);
         next_cycle();
         in_valid_b = 1'b0;
         total += 3;
         if (out_valid_b !== 1'b1) begin bad++; $display("FAIL x64_rnd%0d_valid: got %b want 1", i, out_valid_b); end
         if (immext_b !== r)       begin bad++; $display("FAIL x64_rnd%0d_immext: got %h want %h", i, immext_b, r); end
         if (illegal_b !== ill)    begin bad++; $display("FAIL x64_rnd%0d_illegal: got %b want %b", i, illegal_b, ill); end
         next_cycle();
      end
      // Single-register mode: stall, then simultaneous accept and consume.
      out_ready_b = 1'b0; imm_src_b = 3'd0; in_valid_b = 1'b1; instr_b = 32'h00A00093;
      next_cycle();
      instr_b = 32'h00B00093;
      total += 2;
      if (in_ready_b !== 1'b0)  begin bad++; $display("FAIL x64_stall_rdy: got %b want 0", in_ready_b); end
      if (occupancy_b !== 2'd1) begin bad++; $display("FAIL x64_stall_occ: got %0d want 1", occupancy_b); end
      next_cycle();
      total += 2;
      if (occupancy_b !== 2'd1)  begin bad++; $display("FAIL x64_hold_occ: got %0d want 1", occupancy_b); end
      if (immext_b !== 64'd10)   begin bad++; $display("FAIL x64_hold_imm: got %h want a", immext_b); end
      out_ready_b = 1'b1;
      #1;
      total++;
      if (in_ready_b !== 1'b1) begin bad++; $display("FAIL x64_comb_rdy: got %b want 1", in_ready_b); end
      next_cycle();
      in_valid_b = 1'b0;
      total += 2;
      if (occupancy_b !== 2'd1) begin bad++; $display("FAIL x64_swap_occ: got %0d want 1", occupancy_b); end
      if (immext_b !== 64'd11)  begin bad++; $display("FAIL x64_swap_imm: got %h want b", immext_b); end
      next_cycle();
      total++;
      if (out_valid_b !== 1'b0) begin bad++; $display("FAIL x64_drain: got %b want 0", out_valid_b); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      instr = '0; imm_src = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      instr_b = '0; imm_src_b = '0; in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b0;
      #1;
      test_reset();
      test_vectors32();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      test_xlen64();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
